// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types, defaults and DAC level function for the SAR converter
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CONV   = 2'd2,
        DONE   = 2'd3
    } sar_state_e;

    localparam int SMPL_CYCLES_DEF = 2;

    // Ideal binary-weighted DAC level. A collapsed or inverted reference
    // pins every level to vref_l so the search degenerates to all-ones/zero.
    function automatic real level(input longint unsigned code, input int n_bits,
                                  input real vref_h, input real vref_l);
        if (vref_h <= vref_l) begin
            return vref_l;
        end
        return vref_l + (vref_h - vref_l) * real'(code) / real'(64'd1 << n_bits);
    endfunction

endpackage

// File: rtl/sar_dac_level.sv
// rtl/sar_dac_level.sv - combinational code to real DAC level converter
// Ports:
//   i_Code   [N_BITS]  DAC code
//   i_Vref_H real      upper reference
//   i_Vref_L real      lower reference
//   o_Level  real      level(i_Code)
module sar_dac_level
    import sar_pkg::*;
#(
    parameter int N_BITS = 8
) (
    input  logic [N_BITS-1:0] i_Code,
    input  real               i_Vref_H,
    input  real               i_Vref_L,
    output real               o_Level
);

    assign o_Level = level(64'(i_Code), N_BITS, i_Vref_H, i_Vref_L);

endmodule

// File: rtl/sar_dac_conv.sv
// rtl/sar_dac_conv.sv - SAR ADC front end: sample/hold, binary search, program-mode DAC
// Ports:
//   i_Clk, i_Rst (sync, active high)
//   i_Start  conversion request, honoured only in IDLE
//   i_Sprg   program mode, IDLE DAC level follows i_Code
//   i_Code   direct DAC code
//   i_Vin, i_Vref_H, i_Vref_L  analog input and references
//   o_Busy   high in SAMPLE and CONV
//   o_Valid  one-cycle pulse while o_Code is fresh
//   o_Code   last conversion result
//   o_Vdac   registered DAC level
// Build option: SAR_RANGE_CHECK_EN compiles in range/handshake assertions.
module sar_dac_conv
    import sar_pkg::*;
#(
    parameter int N_BITS      = 8,
    parameter int SMPL_CYCLES = SMPL_CYCLES_DEF
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Start,
    input  logic              i_Sprg,
    input  logic [N_BITS-1:0] i_Code,
    input  real               i_Vin,
    input  real               i_Vref_H,
    input  real               i_Vref_L,
    output logic              o_Busy,
    output logic              o_Valid,
    output logic [N_BITS-1:0] o_Code,
    output real               o_Vdac
);

    localparam int KW = $clog2(N_BITS);
    localparam int CW = $clog2(SMPL_CYCLES + 1);
    localparam logic [KW-1:0]     K_TOP    = KW'(N_BITS - 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(SMPL_CYCLES - 1);
    localparam logic [N_BITS-1:0] ONE      = N_BITS'(1);

    sar_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [KW-1:0]     k_q, k_d;
    logic [N_BITS-1:0] result_q, result_d;
    logic [N_BITS-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    real               vhold_q, vhold_d;
    real               vdac_q, vdac_d;

    logic [N_BITS-1:0] trial;
    logic [N_BITS-1:0] dac_code;
    real               dac_level;

    assign trial = result_q | (ONE << k_q);

    // One converter shared by program mode, the trial search and the final level.
    always_comb begin
        dac_code = i_Code;
        case (state_q)
            CONV:    dac_code = trial;
            DONE:    dac_code = result_q;
            default: dac_code = i_Code;
        endcase
    end

    sar_dac_level #(.N_BITS(N_BITS)) u_level (
        .i_Code   (dac_code),
        .i_Vref_H (i_Vref_H),
        .i_Vref_L (i_Vref_L),
        .o_Level  (dac_level)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        result_d = result_q;
        code_d   = code_q;
        valid_d  = 1'b0;
        vhold_d  = vhold_q;
        vdac_d   = vdac_q;
        case (state_q)
            IDLE: begin
                if (i_Start) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else if (i_Sprg) begin
                    vdac_d = dac_level;
                end
            end
            SAMPLE: begin
                vdac_d = i_Vin;
                if (cnt_q == CNT_LAST) begin
                    vhold_d  = i_Vin;
                    k_d      = K_TOP;
                    result_d = '0;
                    state_d  = CONV;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CONV: begin
                vdac_d = dac_level;
                if (vhold_q >= dac_level) begin
                    result_d = trial;
                end
                // The final decision is published directly so o_Code and
                // o_Valid are both current throughout the DONE cycle.
                if (k_q == '0) begin
                    state_d = DONE;
                    code_d  = result_d;
                    valid_d = 1'b1;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            DONE: begin
                vdac_d  = dac_level;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            result_q <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            vhold_q  <= 0.0;
            vdac_q   <= 0.0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            result_q <= result_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            vhold_q  <= vhold_d;
            vdac_q   <= vdac_d;
        end
    end

    assign o_Busy  = (state_q == SAMPLE) || (state_q == CONV);
    assign o_Valid = valid_q;
    assign o_Code  = code_q;
    assign o_Vdac  = vdac_q;

`ifdef SAR_RANGE_CHECK_EN
    // The first CONV cycle still shows the tracked input, so the range
    // check starts once a trial level has been registered.
    a_vdac_range: assert property (@(posedge i_Clk) disable iff (i_Rst)
        ((state_q == DONE) || (state_q == CONV && k_q != K_TOP)) |->
            (o_Vdac >= ((i_Vref_L < i_Vref_H) ? i_Vref_L : i_Vref_H) &&
             o_Vdac <= ((i_Vref_L < i_Vref_H) ? i_Vref_H : i_Vref_L)));
    a_valid_pulse: assert property (@(posedge i_Clk) disable iff (i_Rst)
        o_Valid |=> !o_Valid);
    a_busy_valid: assert property (@(posedge i_Clk) disable iff (i_Rst)
        !(o_Busy && o_Valid));
`else
`endif

endmodule

// File: tb/tb_sar_dac_conv.sv
// tb/tb_sar_dac_conv.sv - scoreboard bench for sar_dac_conv
module tb_sar_dac_conv;
    import sar_pkg::*;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic       i_Start = 1'b0;
    logic       i_Sprg = 1'b0;
    logic [7:0] i_Code = 8'h00;
    real        i_Vin = 0.0;
    real        i_Vref_H = 1.0;
    real        i_Vref_L = 0.0;
    logic       o_Busy;
    logic       o_Valid;
    logic [7:0] o_Code;
    real        o_Vdac;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int  exp_q[$];
    int  cyc_q[$];
    int  m_exp;
    int  m_cyc;
    bit  vdac_pend = 1'b0;
    real vdac_exp = 0.0;

    sar_dac_conv #(.N_BITS(8), .SMPL_CYCLES(2)) dut (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Start  (i_Start),
        .i_Sprg   (i_Sprg),
        .i_Code   (i_Code),
        .i_Vin    (i_Vin),
        .i_Vref_H (i_Vref_H),
        .i_Vref_L (i_Vref_L),
        .o_Busy   (o_Busy),
        .o_Valid  (o_Valid),
        .o_Code   (o_Code),
        .o_Vdac   (o_Vdac)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic chk_i(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_r(input string nm, input real act, input real exp);
        real d;
        d = act - exp;
        total++;
        if (d > 1.0e-9 || d < -1.0e-9) begin
            bad++;
            $display("FAIL %s: got %f expected %f", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every o_Valid pulse.
    always @(negedge i_Clk) begin
        if (vdac_pend) begin
            chk_r("vdac_after_done", o_Vdac, vdac_exp);
            vdac_pend = 1'b0;
        end
        if (!i_Rst && o_Valid) begin
            chk_i("busy_with_valid", int'(o_Busy), 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got code 0x%0h at cycle %0d expected no pulse", o_Code, cyc);
            end else begin
                m_exp = exp_q.pop_front();
                m_cyc = cyc_q.pop_front();
                chk_i("code", int'(o_Code), m_exp);
                chk_i("latency_cycle", cyc, m_cyc);
                vdac_exp = level(64'(m_exp), 8, i_Vref_H, i_Vref_L);
                vdac_pend = 1'b1;
            end
        end
    end

    // Called at a negedge; returns one negedge after the accepting edge.
    task automatic start_conv(input real vin, input int exp);
        i_Vin = vin;
        i_Start = 1'b1;
        exp_q.push_back(exp);
        cyc_q.push_back(cyc + 11);
        @(negedge i_Clk);
        i_Start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge i_Clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
        repeat (2) @(negedge i_Clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge i_Clk);
        chk_i("rst_busy", int'(o_Busy), 0);
        chk_i("rst_valid", int'(o_Valid), 0);
        chk_i("rst_code", int'(o_Code), 0);
        chk_r("rst_vdac", o_Vdac, 0.0);
        i_Rst = 1'b0;
        @(negedge i_Clk);

        start_conv(0.5, 8'h80);
        chk_i("busy_first_sample", int'(o_Busy), 1);
        wait_drain();

        start_conv(0.3, 8'h4C);
        repeat (3) @(negedge i_Clk);
        chk_r("trial0", o_Vdac, 0.5);
        @(negedge i_Clk);
        chk_r("trial1", o_Vdac, 0.25);
        @(negedge i_Clk);
        chk_r("trial2", o_Vdac, 0.375);
        wait_drain();

        start_conv(1.2, 8'hFF);
        wait_drain();
        start_conv(-0.1, 8'h00);
        wait_drain();
        start_conv(0.75, 8'hC0);
        wait_drain();

        i_Sprg = 1'b1;
        i_Code = 8'h40;
        @(negedge i_Clk);
        chk_r("prog_level", o_Vdac, 0.25);
        i_Sprg = 1'b0;
        i_Code = 8'hFF;
        @(negedge i_Clk);
        chk_r("prog_hold", o_Vdac, 0.25);

        i_Sprg = 1'b1;
        start_conv(0.5, 8'h80);
        chk_r("start_beats_prog", o_Vdac, 0.25);
        i_Sprg = 1'b0;
        wait_drain();

        start_conv(0.6, 8'h99);
        exp_q.delete();
        cyc_q.delete();
        repeat (4) @(negedge i_Clk);
        i_Rst = 1'b1;
        @(negedge i_Clk);
        i_Rst = 1'b0;
        chk_i("abort_busy", int'(o_Busy), 0);
        chk_i("abort_code", int'(o_Code), 0);
        chk_i("abort_valid", int'(o_Valid), 0);
        repeat (15) @(negedge i_Clk);

        start_conv(0.3, 8'h4C);
        wait_drain();

        start_conv(0.6, 8'h99);
        @(negedge i_Clk);
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        i_Vin = 0.9;
        repeat (2) @(negedge i_Clk);
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        n = 0;
        while (!o_Valid && n < 30) begin
            @(negedge i_Clk);
            n++;
        end
        if (!o_Valid) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: got no pulse expected a pulse within 30 cycles");
        end
        @(negedge i_Clk);
        start_conv(0.25, 8'h40);
        wait_drain();

        i_Vref_H = 0.2;
        i_Vref_L = 0.5;
        start_conv(0.6, 8'hFF);
        wait_drain();
        start_conv(0.4, 8'h00);
        wait_drain();

        i_Vref_H = 2.0;
        i_Vref_L = 1.0;
        start_conv(1.5, 8'h80);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sar_dac_conv.md
# sar_dac_conv

Parametrised real-number model of a successive-approximation ADC front end: capacitive DAC, sample/hold, and SAR control loop. It extends the four-mode sample/program DAC mux to N-bit binary-search conversion with a start/valid handshake and a programmable direct-code mode. It sits between the analog input RNM sources and the digital back end, and drives the DAC level for comparator and range checking.

## Interface
- N_BITS, 8, conversion resolution in bits (≥2)
- SMPL_CYCLES, 2, number of cycles the input is tracked before hold (≥1)

- i_Clk  input  1  clock, all state updates on rising edge
- i_Rst  input  1  synchronous, active-high reset
- i_Start  input  1  conversion request; accepted only in IDLE
- i_Sprg  input  1  program mode; in IDLE, DAC level follows i_Code
- i_Code  input  N_BITS  direct DAC code for program mode
- i_Vin  input  real  analog input
- i_Vref_H  input  real  upper reference
- i_Vref_L  input  real  lower reference
- o_Busy  output  1  high in SAMPLE and CONV
- o_Valid  output  1  one-cycle pulse when o_Code is new
- o_Code  output  N_BITS  last conversion result, held until the next DONE
- o_Vdac  output  real  registered DAC level

## Operation
- The DAC level of a code c is level(c) = Vref_L + (Vref_H − Vref_L)·c / 2^N_BITS. The computation is real-valued, with no rounding.
- States: IDLE, SAMPLE, CONV, DONE.
- IDLE:
  - i_Start=1 → SAMPLE, with the sample counter cleared.
  - i_Sprg=1 → o_Vdac ← level(i_Code).
  - Otherwise o_Vdac holds its value.
  - If i_Start and i_Sprg are both 1, i_Start wins: the state goes to SAMPLE and program mode is ignored that cycle.
- SAMPLE:
  - Every cycle, o_Vdac ← i_Vin (track).
  - On the SMPL_CYCLES-th cycle, Vhold ← i_Vin, trial bit k ← N_BITS−1, result ← 0, and the state goes to CONV.
- CONV:
  - Each cycle: trial = result | (1<<k); o_Vdac ← level(trial).
  - If Vhold ≥ level(trial), bit k of the result is set.
  - k decrements each cycle. After k=0 the state goes to DONE.
- DONE:
  - o_Code ← result and o_Valid=1 for this cycle only.
  - o_Vdac ← level(result).
  - Next state is IDLE.
- i_Start outside IDLE is ignored; it is neither queued nor errored.
- Out-of-range input clamps naturally:
  - Vin ≥ Vref_H gives code all-ones.
  - Vin < Vref_L gives code 0.
- If Vref_H ≤ Vref_L, every trial level is Vref_L. The result is all-ones if Vhold ≥ Vref_L, otherwise 0.
- Reset:
  - State ← IDLE; o_Busy=0, o_Valid=0, o_Code=0, o_Vdac=0.0, Vhold=0.0.
  - Reset mid-SAMPLE or mid-CONV aborts the conversion. No o_Valid pulse is issued, and o_Code is cleared.

## Timing
- Start accepted at edge t. SAMPLE occupies cycles t+1 … t+SMPL_CYCLES, CONV the next N_BITS cycles, and DONE one cycle.
- Latency from start to o_Valid is SMPL_CYCLES + N_BITS + 1 cycles (11 at the defaults).
- o_Busy rises in the first SAMPLE cycle and falls in the DONE cycle.
- The earliest next start is accepted in the cycle after DONE. Back-to-back conversion throughput is SMPL_CYCLES + N_BITS + 2 cycles.
- o_Vdac is registered. It reflects the current state's level one edge after the state is entered.
- i_Vin is sampled on the last SAMPLE edge only. Changes during CONV do not affect the result.

## Configuration
- SAR_RANGE_CHECK_EN defined: concurrent assertions are compiled in:
  - o_Vdac within [min(Vref_L,Vref_H), max(Vref_L,Vref_H)] in CONV and DONE.
  - o_Valid never high in two consecutive cycles.
  - o_Busy and o_Valid never high together.
- SAR_RANGE_CHECK_EN undefined: no assertions. Functional behaviour is identical.

## Structure
- The shared package sar_pkg holds:
  - the state enum typedef (IDLE, SAMPLE, CONV, DONE);
  - the default SMPL_CYCLES constant;
  - a real function level(code, n_bits, vref_h, vref_l) used by both the RTL and the bench models.
- Sub-module sar_dac_level: combinational code→real level converter, parametrised by N_BITS and instantiated once for the trial/program level.

## Test plan
- Defaults, Vref_L=0.0, Vref_H=1.0, Vin=0.5, start pulse → o_Valid exactly 11 cycles later, o_Code=0x80, o_Vdac=0.5.
- Vin=0.3 → o_Code=0x4C. The o_Vdac trial sequence starts 0.5, 0.25, 0.375, ….
- Vin=1.2 → o_Code=0xFF. Vin=−0.1 → o_Code=0x00. Run with SAR_RANGE_CHECK_EN defined; no assertion fails.
- IDLE, i_Sprg=1, i_Code=0x40 → o_Vdac=0.25 after one edge. Drop i_Sprg → o_Vdac holds 0.25.
- i_Rst asserted in the 3rd CONV cycle → next cycle IDLE, o_Code=0, o_Busy=0, no o_Valid. A new start then converts normally.
- i_Start pulsed during SAMPLE and CONV → ignored; exactly one o_Valid. A start in the cycle after DONE is accepted.
